prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 20 ++
 rtl/prog_loader_if.sv | 9 +
 rtl/prog_loader.sv | 100 ++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared states and frame constants for the program loader
package prog_loader_pkg;

    localparam logic [7:0] DEF_HEADER    = 8'hA5;
    localparam int         DEF_NUM_WORDS = 16;
    localparam int         REC_LEN       = 2;

    typedef enum logic [3:0] {
        IDLE,
        GET_INS,
        GET_DAT,
        SETUP,
        STROBE,
        HOLD,
        GET_SUM,
        DONE,
        ERR
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - host byte link carrying the load frame
interface prog_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - receives a checksummed frame and writes it into the computer's program/data memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0] HEADER    = DEF_HEADER,
    parameter int         NUM_WORDS = DEF_NUM_WORDS
) (
    input  logic               osc_clock,
    input  logic               reset_n,
    prog_loader_if.slave       host,
    output logic [3:0]         prog_add,
    output logic [7:0]         prog_in,
    output logic [3:0]         prog_data,
    output logic               prog_clk,
    output logic               cpu_reset,
    output logic               load_done,
    output logic               load_err
);

    localparam logic [3:0] LAST_ADDR = 4'(NUM_WORDS - 1);

    state_t     state, state_nx;
    logic [7:0] csum;
    logic       accept;

    // The write strobe sequence owns the buses, so the host is held off for those three cycles.
    assign host.in_ready = !(state inside {SETUP, STROBE, HOLD});
    assign accept        = host.in_valid && host.in_ready;

    always_ff @(posedge osc_clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, ERR: if (accept && host.in_data == HEADER) state_nx = GET_INS;
            GET_INS:         if (accept) state_nx = GET_DAT;
            GET_DAT:         if (accept) state_nx = SETUP;
            SETUP:           state_nx = STROBE;
            STROBE:          state_nx = HOLD;
            HOLD:            state_nx = (prog_add == LAST_ADDR) ? GET_SUM : GET_INS;
            GET_SUM:         if (accept) state_nx = (host.in_data == csum) ? DONE : ERR;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge osc_clock or negedge reset_n) begin
        if (!reset_n) begin
            prog_add  <= '0;
            prog_in   <= '0;
            prog_data <= '0;
            prog_clk  <= 1'b0;
            cpu_reset <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            csum      <= '0;
        end else begin
            // Registered from the next state so the strobe is high exactly while in STROBE.
            prog_clk <= (state_nx == STROBE);
            case (state)
                IDLE, DONE, ERR: begin
                    if (accept && host.in_data == HEADER) begin
                        prog_add  <= '0;
                        csum      <= '0;
                        load_done <= 1'b0;
                        load_err  <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                GET_INS: begin
                    if (accept) begin
                        prog_in <= host.in_data;
                        csum    <= csum + host.in_data;
                    end
                end
                GET_DAT: begin
                    if (accept) begin
                        prog_data <= host.in_data[3:0];
                        csum      <= csum + host.in_data;
                    end
                end
                HOLD: prog_add <= prog_add + 4'd1;
                GET_SUM: begin
                    if (accept) begin
                        if (host.in_data == csum) begin
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader
module tb_prog_loader;

    localparam logic [7:0] GOOD_SUM = 8'hF0;

    logic       osc_clock = 1'b0;
    logic       reset_n;
    logic [3:0] prog_add;
    logic [7:0] prog_in;
    logic [3:0] prog_data;
    logic       prog_clk;
    logic       cpu_reset;
    logic       load_done;
    logic       load_err;

    prog_loader_if bus ();

    prog_loader #(.HEADER(8'hA5), .NUM_WORDS(16)) dut (
        .osc_clock (osc_clock),
        .reset_n   (reset_n),
        .host      (bus.slave),
        .prog_add  (prog_add),
        .prog_in   (prog_in),
        .prog_data (prog_data),
        .prog_clk  (prog_clk),
        .cpu_reset (cpu_reset),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 osc_clock = ~osc_clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] pa_q[$];
    logic [7:0] pi_q[$];
    logic [3:0] pd_q[$];
    int         run_q[$];
    int         width_err = 0;
    int         stab_err  = 0;
    int         run       = 0;
    logic       prev_clk  = 1'b0;
    logic [3:0] prev_add;
    logic [7:0] prev_in;
    logic [3:0] prev_data;

    always @(negedge osc_clock) begin
        if (!reset_n) begin
            prev_clk = 1'b0;
            run      = 0;
        end else begin
            if (prog_clk) begin
                if (prev_clk) width_err++;
                else begin
                    pa_q.push_back(prog_add);
                    pi_q.push_back(prog_in);
                    pd_q.push_back(prog_data);
                    if (prog_add != prev_add || prog_in != prev_in || prog_data != prev_data) stab_err++;
                end
            end else if (prev_clk) begin
                if (prog_add != prev_add || prog_in != prev_in || prog_data != prev_data) stab_err++;
            end
            if (!bus.in_ready) run++;
            else if (run != 0) begin
                run_q.push_back(run);
                run = 0;
            end
            prev_clk = prog_clk;
        end
        prev_add  = prog_add;
        prev_in   = prog_in;
        prev_data = prog_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pa_q.delete();
        pi_q.delete();
        pd_q.delete();
        run_q.delete();
        width_err = 0;
        stab_err  = 0;
    endtask

    // Called and returns on a falling edge; gap adds idle cycles with in_valid low.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit keep);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (!bus.in_ready && t < 50) begin
            @(negedge osc_clock);
            t++;
        end
        if (!bus.in_ready) check("in_ready_wait", bus.in_ready, 1);
        @(posedge osc_clock);
        @(negedge osc_clock);
        if (!keep) bus.in_valid = 1'b0;
        repeat (gap) @(negedge osc_clock);
    endtask

    task automatic send_frame(input logic [7:0] sum, input int gap, input bit keep);
        send_byte(8'hA5, gap, keep);
        check("hdr_cpu_reset", cpu_reset, 1);
        check("hdr_load_done", load_done, 0);
        check("hdr_load_err", load_err, 0);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'h70 + 8'(i), gap, keep);
            send_byte(8'(i), gap, keep);
        end
        send_byte(sum, gap, 1'b0);
    endtask

    task automatic verify_load(input string tag);
        int bad_runs = 0;
        check({tag, "_pulses"}, pa_q.size(), 16);
        for (int i = 0; i < 16 && i < pa_q.size(); i++) begin
            check($sformatf("%s_add%0d", tag, i), pa_q[i], i);
            check($sformatf("%s_ins%0d", tag, i), pi_q[i], 8'h70 + i);
            check($sformatf("%s_dat%0d", tag, i), pd_q[i], i);
        end
        check({tag, "_strobe_width"}, width_err, 0);
        check({tag, "_bus_stable"}, stab_err, 0);
        check({tag, "_busy_windows"}, run_q.size(), 16);
        foreach (run_q[i]) if (run_q[i] != 3) bad_runs++;
        check({tag, "_busy_len"}, bad_runs, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge osc_clock);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_prog_clk", prog_clk, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_prog_add", prog_add, 0);
        reset_n = 1'b1;
        @(negedge osc_clock);

        clear_mon();
        send_frame(GOOD_SUM, 1, 1'b0);
        check("good_load_done", load_done, 1);
        check("good_load_err", load_err, 0);
        check("good_cpu_reset", cpu_reset, 0);
        check("good_in_ready", bus.in_ready, 1);
        verify_load("good");

        clear_mon();
        send_byte(8'h00, 1, 1'b0);
        send_byte(8'hFF, 1, 1'b0);
        send_byte(8'h5A, 1, 1'b0);
        check("garbage_pulses", pa_q.size(), 0);
        check("garbage_load_done", load_done, 1);
        check("garbage_cpu_reset", cpu_reset, 0);

        send_frame(GOOD_SUM, 0, 1'b1);
        check("bp_load_done", load_done, 1);
        check("bp_cpu_reset", cpu_reset, 0);
        verify_load("bp");

        clear_mon();
        send_frame(GOOD_SUM + 8'd1, 0, 1'b0);
        check("bad_load_err", load_err, 1);
        check("bad_load_done", load_done, 0);
        check("bad_cpu_reset", cpu_reset, 1);
        verify_load("bad");

        send_byte(8'hA5, 0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            send_byte(8'h70 + 8'(i), 0, 1'b0);
            send_byte(8'(i), 0, 1'b0);
        end
        t = 0;
        while (!prog_clk && t < 10) begin
            @(negedge osc_clock);
            t++;
        end
        check("mid_strobe_seen", prog_clk, 1);
        check("mid_strobe_add", prog_add, 7);
        reset_n = 1'b0;
        #1;
        check("mid_rst_prog_clk", prog_clk, 0);
        check("mid_rst_cpu_reset", cpu_reset, 1);
        check("mid_rst_prog_add", prog_add, 0);
        @(negedge osc_clock);
        check("mid_rst_in_ready", bus.in_ready, 1);
        reset_n = 1'b1;
        @(negedge osc_clock);

        clear_mon();
        send_frame(GOOD_SUM, 0, 1'b0);
        check("reload_load_done", load_done, 1);
        check("reload_cpu_reset", cpu_reset, 0);
        verify_load("reload");

        send_byte(8'hA5, 0, 1'b0);
        check("rehdr_cpu_reset", cpu_reset, 1);
        check("rehdr_load_done", load_done, 0);
        check("rehdr_in_ready", bus.in_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
